// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder and the core's MEM stage.
// Covers access sizes, FSM states, latency counter width and the funct3 decode.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Wide enough for the largest supported latency of 15 cycles.
    localparam int LAT_CNT_W = 4;

    // RV32 load/store funct3: [1:0] selects the width and [2] marks LBU/LHU.
    // funct3 values with no RV32 meaning (LD/LWU and friends) map to SIZE_X so they fault.
    function automatic size_e funct3_to_size(input logic [2:0] funct3);
        if (funct3[1:0] == 2'b11 || (funct3[2] && funct3[1]))
            return SIZE_X;
        return size_e'(funct3[1:0]);
    endfunction

    function automatic logic funct3_is_unsigned(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the core's MEM stage and the responder.
interface dmem_responder_if #(
    parameter int DATAW = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_rw;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [DATAW-1:0] req_addr;
    logic [DATAW-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [DATAW-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_rw, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: store enables/replication
// and load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  size_e              size,
    input  logic [1:0]         addr_lo,
    input  logic               is_unsigned,
    input  logic [DATAW-1:0]   wdata,
    input  logic [DATAW-1:0]   rword,
    output logic [DATAW/8-1:0] be,
    output logic [DATAW-1:0]   wword,
    output logic [DATAW-1:0]   rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be       = '0;
        wword    = '0;
        rdata    = '0;
        byte_sel = rword[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SIZE_B: begin
                be    = 4'b0001 << addr_lo;
                wword = {(DATAW/8){wdata[7:0]}};
                rdata = {{(DATAW-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {(DATAW/16){wdata[15:0]}};
                rdata = {{(DATAW-16){~is_unsigned & half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                be    = '1;
                wword = wdata;
                rdata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable access latency.
// Storage is touched only at request acceptance; the response is held until consumed.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int               DATAW       = 32,
    parameter logic [DATAW-1:0] BASE_ADDR   = 32'h01000000,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATAW-1:0]       rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [DATAW-1:0]       mem [DEPTH_WORDS];
    logic [DATAW-1:0]       word_off;
    logic [IDXW-1:0]        idx;
    logic [DATAW-1:0]       rword;
    logic [DATAW-1:0]       wword;
    logic [DATAW-1:0]       ext_rdata;
    logic [DATAW/8-1:0]     be;
    logic                   misaligned;
    logic                   req_err;
    logic                   mem_we;
    size_e                  req_size_e;

    assign req_size_e = size_e'(bus.req_size);

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
    assign word_off = (bus.req_addr - BASE_ADDR) >> 2;
    assign idx      = word_off[IDXW-1:0];
    assign rword    = mem[idx];

    always_comb begin
        misaligned = 1'b0;
        case (req_size_e)
            SIZE_H:  misaligned = bus.req_addr[0];
            SIZE_W:  misaligned = (bus.req_addr[1:0] != 2'b00);
            SIZE_X:  misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign req_err = misaligned || (word_off >= DATAW'(DEPTH_WORDS));

    dmem_lane_align #(.DATAW(DATAW)) u_align (
        .size        (req_size_e),
        .addr_lo     (bus.req_addr[1:0]),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (rword),
        .be          (be),
        .wword       (wword),
        .rdata       (ext_rdata)
    );

    assign mem_we = bus.req_valid && (state_q == ST_IDLE) && bus.req_rw && !req_err && !reset;

    always_ff @(posedge clock) begin
        for (int i = 0; i < DATAW/8; i++) begin
            if (mem_we && be[i])
                mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    err_d   = req_err;
                    rdata_d = (req_err || bus.req_rw) ? '0 : ext_rdata;
                    if (LATENCY > 1) begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT_CNT_W'(1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == LAT_CNT_W'(LATENCY - 1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response fields read as zero whenever no response is being offered.
    assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.resp_err   = (state_q == ST_RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with LATENCY=2, plus
// hand-written sequences for response back-pressure and reset during BUSY.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam int          LAT  = 2;

    typedef struct {
        string       name;
        logic        rw;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    dmem_responder_if #(.DATAW(32)) bus();

    dmem_responder #(
        .DATAW       (32),
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic vec_t mkVec(input string name, input logic rw, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                   input logic exp_err);
        vec_t v;
        v.name = name; v.rw = rw; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveReq(input vec_t v, input logic resp_rdy);
        bus.req_rw       = v.rw;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.resp_ready   = resp_rdy;
        bus.req_valid    = 1'b1;
    endtask

    // Waits from the acceptance edge until resp_valid shows, sampling on negedges.
    task automatic waitResp(input string name);
        int cycles = 0;
        while (cycles < 20) begin
            @(negedge clock);
            cycles++;
            if (bus.resp_valid) break;
        end
        checkOutput({name, " latency"}, 32'(cycles), 32'(LAT));
    endtask

    task automatic applyStimulus(input vec_t v);
        int waited = 0;
        @(negedge clock);
        driveReq(v, 1'b1);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput({v.name, " req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        waitResp(v.name);
        checkOutput({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
        checkOutput({v.name, " err"}, {31'b0, bus.resp_err}, {31'b0, v.exp_err});
        @(posedge clock);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_rw       = 1'b0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;

        vecs.push_back(mkVec("sw_base",  1, SIZE_W, 0, BASE,       32'hDEADBEEF, 32'h00000000, 0));
        vecs.push_back(mkVec("lw_base",  0, SIZE_W, 0, BASE,       32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mkVec("sw_b4",    1, SIZE_W, 0, BASE + 4,   32'h0,        32'h00000000, 0));
        vecs.push_back(mkVec("sb_b5",    1, SIZE_B, 0, BASE + 5,   32'h00000080, 32'h00000000, 0));
        vecs.push_back(mkVec("lb_b5",    0, SIZE_B, 0, BASE + 5,   32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mkVec("lbu_b5",   0, SIZE_B, 1, BASE + 5,   32'h0,        32'h00000080, 0));
        vecs.push_back(mkVec("lw_b4",    0, SIZE_W, 0, BASE + 4,   32'h0,        32'h00008000, 0));
        vecs.push_back(mkVec("sh_b6",    1, SIZE_H, 0, BASE + 6,   32'h00001234, 32'h00000000, 0));
        vecs.push_back(mkVec("lh_b6",    0, SIZE_H, 0, BASE + 6,   32'h0,        32'h00001234, 0));
        vecs.push_back(mkVec("lw_b4_2",  0, SIZE_W, 0, BASE + 4,   32'h0,        32'h12348000, 0));
        vecs.push_back(mkVec("lh_mis",   0, SIZE_H, 0, BASE + 1,   32'h0,        32'h00000000, 1));
        vecs.push_back(mkVec("lw_low",   0, SIZE_W, 0, BASE - 4,   32'h0,        32'h00000000, 1));
        vecs.push_back(mkVec("sz_ill",   0, SIZE_X, 0, BASE,       32'h0,        32'h00000000, 1));
        vecs.push_back(mkVec("sw_mis",   1, SIZE_W, 0, BASE + 2,   32'hCAFEF00D, 32'h00000000, 1));
        vecs.push_back(mkVec("sw_top",   1, SIZE_W, 0, BASE + 4096, 32'h12345678, 32'h00000000, 1));
        vecs.push_back(mkVec("sw_last",  1, SIZE_W, 0, BASE + 4092, 32'hA5A55A5A, 32'h00000000, 0));
        vecs.push_back(mkVec("lw_last",  0, SIZE_W, 0, BASE + 4092, 32'h0,        32'hA5A55A5A, 0));
        vecs.push_back(mkVec("sw_b12",   1, SIZE_W, 0, BASE + 12,  32'hF00F8001, 32'h00000000, 0));
        vecs.push_back(mkVec("lh_b14",   0, SIZE_H, 0, BASE + 14,  32'h0,        32'hFFFFF00F, 0));
        vecs.push_back(mkVec("lhu_b12",  0, SIZE_H, 1, BASE + 12,  32'h0,        32'h00008001, 0));
        vecs.push_back(mkVec("lb_b15",   0, SIZE_B, 0, BASE + 15,  32'h0,        32'hFFFFFFF0, 0));
        vecs.push_back(mkVec("lbu_b13",  0, SIZE_B, 1, BASE + 13,  32'h0,        32'h00000080, 0));
        vecs.push_back(mkVec("sw_b16",   1, SIZE_W, 0, BASE + 16,  32'h0,        32'h00000000, 0));
        vecs.push_back(mkVec("sb_b18",   1, SIZE_B, 0, BASE + 18,  32'hFFFFFF12, 32'h00000000, 0));
        vecs.push_back(mkVec("lw_b16",   0, SIZE_W, 0, BASE + 16,  32'h0,        32'h00120000, 0));
        vecs.push_back(mkVec("lwu_base", 0, SIZE_W, 1, BASE,       32'h0,        32'hDEADBEEF, 0));

        // Reset state, sampled right after reset drops.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst req_ready",  {31'b0, bus.req_ready},  32'd1);
        checkOutput("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("rst resp_rdata", bus.resp_rdata,           32'd0);
        checkOutput("rst resp_err",   {31'b0, bus.resp_err},   32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Back-pressure: response must hold steady while resp_ready is low.
        @(negedge clock);
        driveReq(mkVec("stall", 0, SIZE_W, 0, BASE, 32'h0, 32'hDEADBEEF, 0), 1'b0);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        waitResp("stall");
        checkOutput("stall rdata", bus.resp_rdata, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("stall hold valid", {31'b0, bus.resp_valid}, 32'd1);
            checkOutput("stall hold rdata", bus.resp_rdata,           32'hDEADBEEF);
            checkOutput("stall req_ready",  {31'b0, bus.req_ready},  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        checkOutput("stall release req_ready",  {31'b0, bus.req_ready},  32'd1);
        checkOutput("stall release resp_valid", {31'b0, bus.resp_valid}, 32'd0);

        // Reset while BUSY drops the response but keeps the committed store.
        @(negedge clock);
        driveReq(mkVec("rst_busy", 1, SIZE_W, 0, BASE + 8, 32'h00000055, 32'h0, 0), 1'b1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        checkOutput("busy req_ready",  {31'b0, bus.req_ready},  32'd0);
        checkOutput("busy resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("midrst req_ready",  {31'b0, bus.req_ready},  32'd1);
        reset = 1'b0;
        applyStimulus(mkVec("lw_b8", 0, SIZE_W, 0, BASE + 8, 32'h0, 32'h00000055, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the core's load/store port over a valid/ready request/response handshake.
- Holds one outstanding request at a time. Models a configurable access latency.
- Handles byte, half and word lanes, and sign/zero-extends read data.
- Flags misaligned, out-of-range and illegal-size accesses. Sits between the core's MEM stage and backing storage, replacing the fixed-latency dmemory for stall-capable pipelines.

Parameters:
- DATAW, 32, data and address width.
- BASE_ADDR, 32'h01000000, byte address of word 0.
- DEPTH_WORDS, 1024, storage depth in words. Must be a power of 2.
- LATENCY, 2, cycles from request acceptance to resp_valid. Legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_rw  in  1  0=read, 1=write
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  zero-extend byte/half reads (LBU/LHU)
- req_addr  in  DATAW  byte address
- req_wdata  in  DATAW  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  DATAW  extended load data; 0 for writes and errors
- resp_err  out  1  access faulted

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Latency counter=0. Storage contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, go to BUSY if LATENCY>1, else go to RESP.
  - BUSY: counter counts up to LATENCY-1, then go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- req_ready is 1 only in IDLE. There is no overlap: the earliest next acceptance is the cycle after the response handshake.
- Acceptance edge T, where req_valid && req_ready:
  - Latch rw, size, unsigned and addr[1:0].
  - Compute err.
  - For a non-faulting write, commit the enabled byte lanes at this edge.
  - For a non-faulting read, sample the addressed word at this edge into the response register.
- resp_valid rises in the cycle after edge T+LATENCY-1, i.e. it is visible LATENCY cycles after acceptance.
- While resp_ready=0, resp_valid, resp_rdata and resp_err stay stable.
- err = (size==11) OR (size==01 && addr[0]) OR (size==10 && addr[1:0]!=0) OR (addr < BASE_ADDR) OR (addr >= BASE_ADDR + 4*DEPTH_WORDS).
- On err: no storage write, resp_rdata=0, resp_err=1.
- Word index = (addr - BASE_ADDR) >> 2. Layout is little-endian.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100, by addr[1]
  - word: 1111
- Write data is replicated into the selected lanes.
- Read data: shift the selected lane(s) down to bit 0. Sign-extend from bit 7 or bit 15, unless req_unsigned is set. Word reads pass through and ignore req_unsigned.
- Address arithmetic is unsigned. No wrap-around: addresses past the top of storage fault.
- req_valid outside IDLE is ignored. It is not queued.
- Reset mid-operation (BUSY or RESP): return to IDLE next cycle and drop the pending response. A write accepted before reset stays committed.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings (SIZE_B, SIZE_H, SIZE_W)
  - state encoding (ST_IDLE, ST_BUSY, ST_RESP)
  - the LATENCY counter width constant
  - the RISC-V funct3-to-size mapping used by the core
- One combinational sub-module, dmem_lane_align:
  - inputs: size, addr[1:0], unsigned, wdata, read word
  - outputs: byte enables, aligned write word, extended read data
- Storage array and FSM stay in dmem_responder.

Test Plan:
- SW 0xDEADBEEF to BASE_ADDR, accepted at cycle T, resp_ready=1 → resp_valid at T+2 with err=0 and rdata=0. Then LW BASE_ADDR → rdata=0xDEADBEEF.
- SW 0 to BASE+4, then SB 0x80 to BASE+5:
  - LB BASE+5 → 0xFFFFFF80
  - LBU BASE+5 → 0x00000080
  - LW BASE+4 → 0x00008000
- SH 0x1234 to BASE+6, then LH BASE+6 → 0x00001234. LW BASE+4 → 0x12348000.
- LH BASE+1 → err=1, rdata=0. LW BASE-4 → err=1. Access with size=11 → err=1. Re-read BASE_ADDR → still 0xDEADBEEF.
- Hold resp_ready=0 for 3 cycles after resp_valid → resp_valid/rdata stable and req_ready=0 throughout. Assert resp_ready → req_ready=1 next cycle.
- Reset asserted in BUSY after SW 0x55 to BASE+8 → next cycle resp_valid=0 and req_ready=1. LW BASE+8 → 0x00000055.
